sar_magnitude_search: RTL and testbench

Sequential successive-approximation controller that recovers an unknown unsigned value A using only a greater-than comparator. It drives a trial value `probe` onto the comparator's B input and reads back the comparator's `A > B` flag, one bit per two clock cycles, MSB first. The block sits beside the existing combinational magnitude comparator and is the driving end of that interface. It produces `probe` and consumes the comparator's output.

---
 rtl/sar_magnitude_search.sv | 118 +++++++++++
 tb/tb_sar_magnitude_search.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/sar_magnitude_search.sv
// Successive-approximation search that recovers an unknown unsigned A through an
// external greater-than comparator, one result bit per SET/CHK pair, MSB first.
module sar_magnitude_search #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  input  logic         gt,
  output logic [W-1:0] probe,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result
);

  localparam int unsigned IW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SET,
    S_CHK
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q,    idx_d;
  logic [W-1:0]    acc_q,    acc_d;
  logic [W-1:0]    probe_q,  probe_d;
  logic [W-1:0]    result_q, result_d;
  logic            busy_q,   busy_d;
  logic            done_q,   done_d;

  logic [W-1:0]    bit_mask;
  logic [W-1:0]    acc_upd;

  assign bit_mask = W'(1) << idx_q;
  assign acc_upd  = gt ? (acc_q | bit_mask) : acc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      acc_q    <= '0;
      probe_q  <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      probe_q  <= probe_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    probe_d  = probe_q;
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // abort is deliberately ignored here so start wins when both are high
        if (start) begin
          acc_d   = '0;
          idx_d   = IW'(W - 1);
          probe_d = (W'(1) << (W - 1)) - W'(1);
          busy_d  = 1'b1;
          state_d = S_CHK;
        end
      end
      S_SET: begin
        if (abort) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          // trial minus one turns the strict A > B flag into A >= trial
          probe_d = (acc_q | bit_mask) - W'(1);
          state_d = S_CHK;
        end
      end
      S_CHK: begin
        if (abort) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          acc_d = acc_upd;
          if (idx_q == '0) begin
            result_d = acc_upd;
            done_d   = 1'b1;
            busy_d   = 1'b0;
            state_d  = S_IDLE;
          end else begin
            idx_d   = idx_q - IW'(1);
            state_d = S_SET;
          end
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign probe  = probe_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_sar_magnitude_search.sv
// Directed bench for sar_magnitude_search with a combinational comparator model
// and a result scoreboard filled at start and drained on done.
module tb_sar_magnitude_search;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         abort;
  logic         gt;
  logic [W-1:0] probe;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic [W-1:0] a_val;

  int n_cmp = 0;
  int n_err = 0;
  int sb[$];

  sar_magnitude_search #(.W(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .abort  (abort),
    .gt     (gt),
    .probe  (probe),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  assign gt = (a_val > probe);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Issues one search; returns in the done cycle (#1 after its edge).
  task automatic do_search(input int a, input int extra_start_t, input int hold_res,
                           input bit trace);
    int t;
    int macc;
    int trial;
    int bitn;
    bit got;
    a_val = W'(a);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    sb.push_back(a);
    macc = 0;
    t    = 0;
    got  = 1'b0;
    while (t < 40) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      start = (t == extra_start_t);
      if (trace && (t % 2 == 0) && (t < 2 * W)) begin
        bitn  = W - 1 - t / 2;
        trial = macc | (1 << bitn);
        chk("probe_chk", int'(probe), trial - 1);
        chk("gt_chk", int'(gt), int'(a >= trial));
        if (a >= trial) macc = trial;
      end
      if (hold_res >= 0) chk("result_hold", int'(result), hold_res);
      @(posedge clk);
      #1;
      t++;
    end
    start = 1'b0;
    chk("done_seen", int'(got), 1);
    chk("latency", t, 2 * W - 1);
    chk("busy_in_done", int'(busy), 0);
    if (sb.size() > 0) chk("result", int'(result), sb.pop_front());
    else chk("sb_underflow", 1, 0);
  endtask

  initial begin
    int saw;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    a_val = '0;
    #2;
    chk("rst_probe", int'(probe), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_result", int'(result), 0);
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // A=10 worked example: probes 7,11,9,10 and gt 1,0,1,0
    do_search(10, -1, -1, 1'b1);
    @(posedge clk);
    #1;
    chk("done_pulse_width", int'(done), 0);

    for (int a = 0; a < (1 << W); a++) do_search(a, -1, -1, 1'b1);

    // back-to-back: start raised in the done cycle of the first run
    do_search(5, -1, -1, 1'b0);
    do_search(12, -1, 5, 1'b0);
    @(posedge clk);
    #1;

    // start pulses mid-flight must be ignored
    do_search(6, 1, -1, 1'b1);
    do_search(13, 4, -1, 1'b1);
    @(posedge clk);
    #1;

    // abort in the second CHK after a prior result of 3
    do_search(3, -1, -1, 1'b0);
    @(posedge clk);
    #1;
    a_val = W'(10);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("abort_probe_in_chk", int'(probe), 11);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_result", int'(result), 3);
    chk("abort_probe", int'(probe), 11);
    saw = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) saw++;
    end
    chk("abort_quiet", saw, 0);
    chk("abort_probe_hold", int'(probe), 11);

    // asynchronous reset mid-search
    a_val = W'(9);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
    end
    chk("pre_rst_busy", int'(busy), 1);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_probe", int'(probe), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_result", int'(result), 0);
    #1;
    rst_n = 1'b1;
    saw = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) saw++;
    end
    chk("post_rst_quiet", saw, 0);

    do_search(7, -1, -1, 1'b1);
    chk("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
